serv_pc_seq: RTL and testbench
==============================

SERV_PC_SEQ -- requirements
Module: serv_pc_seq

Interface
REQ-001 SHALL have parameter W, default 1: datapath chunk width in bits; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter RESET_PC, default 32'd0: PC value loaded at reset.
REQ-003 SHALL have parameter WITH_CSR, default 1: when 0, the trap path is removed and i_trap is ignored.
REQ-004 SHALL have parameter WITH_C, default 0: when 1, compressed (+2) increment and 2-byte alignment are allowed.
REQ-005 SHALL have ports with one clock; reset is asynchronous and active-low:
  clk  in  1  clock
  i_rst_n  in  1  asynchronous active-low reset
  i_start  in  1  start a PC-update sequence (honoured in IDLE only)
  i_jump  in  1  take the offset target
  i_jal_or_jalr  in  1  drive PC+inc onto o_rd
  i_utype  in  1  LUI/AUIPC: drive the offset sum onto o_rd
  i_pc_rel  in  1  offset operand A = PC (else 0)
  i_trap  in  1  next PC = i_csr_pc
  i_iscomp  in  1  increment 2 (else 4); forced 0 when WITH_C=0
  i_imm  in  W  immediate chunk
  i_buf  in  W  register-operand chunk
  i_csr_pc  in  W  trap vector chunk
  o_rd  out  W  rd result chunk
  o_bad_pc  out  W  aligned target chunk
  o_misalign  out  1  sticky misaligned-jump flag
  o_busy  out  1  state != IDLE
  o_done  out  1  one-cycle pulse on fetch completion
  o_ibus_adr  out  32  current PC
  o_ibus_cyc  out  1  fetch request
  i_ibus_ack  in  1  fetch acknowledge

Function
REQ-006 SHALL implement FSM states IDLE, SHIFT and FETCH; transitions are IDLE->SHIFT on i_start, SHIFT->FETCH after chunk N-1 (N = 32/W), and FETCH->IDLE on i_ibus_ack.
REQ-007 SHALL ignore i_start outside IDLE, and SHALL ignore i_ibus_ack outside FETCH.
REQ-008 SHALL run an internal chunk counter cnt, which is cleared on entry to SHIFT and incremented each SHIFT cycle, giving a SHIFT latency of exactly N cycles.
REQ-009 SHALL use derived strobes: cnt0 = (cnt==0); cnt03 = (cnt*W < 4); cnt12to31 = (cnt*W >= 12).
REQ-010 SHALL, in each SHIFT cycle, compute from pc chunk = o_ibus_adr[W-1:0]:
  - incr = pc + ((inc >> cnt*W) masked to W) + cy4, where inc = i_iscomp ? 2 : 4;
  - offs = (i_pc_rel ? pc : 0) + (i_utype ? (cnt12to31 ? i_imm : 0) : i_buf) + cyo.
REQ-011 SHALL register the carries cy4 and cyo every SHIFT cycle, and SHALL clear both to 0 on entry to SHIFT.
REQ-012 SHALL form aligned = offs with bit 0 forced to 0 in the cnt0 chunk; o_bad_pc = aligned.
REQ-013 SHALL select new_pc chunk with priority i_trap (WITH_CSR=1) > i_jump > else:
  - i_trap: i_csr_pc with bits [1:0] forced 0 in the cnt0 chunk;
  - i_jump: aligned;
  - else: incr.
REQ-014 SHALL update o_ibus_adr <= {new_pc, o_ibus_adr[31:W]} in every SHIFT cycle, and SHALL hold o_ibus_adr in every other state.
REQ-015 SHALL drive o_rd = (i_utype ? aligned : 0) | (i_jal_or_jalr ? incr : 0) during SHIFT, and 0 otherwise.
REQ-016 SHALL clear o_misalign on i_start; o_misalign SHALL be set when WITH_C=0, i_jump=1, i_trap=0 and aligned bit 1 = 1, and SHALL hold until the next i_start.
REQ-017 SHALL update the PC even when o_misalign is set; trap handling is external.
REQ-018 SHALL drive o_ibus_cyc = (state==FETCH); o_ibus_adr SHALL be stable throughout FETCH.
REQ-019 SHALL pulse o_done for the single cycle following the accepted i_ibus_ack.
REQ-020 SHALL perform arithmetic modulo 2^32; the final carry out of chunk N-1 SHALL be discarded, and the PC wraps from 0xFFFFFFFC to 0x00000000.

Reset
REQ-021 SHALL, while i_rst_n=0, asynchronously set:
  - o_ibus_adr = RESET_PC;
  - state = FETCH;
  - cnt = 0, cy4 = 0, cyo = 0;
  - o_misalign = 0, o_done = 0.
REQ-022 SHALL therefore assert o_ibus_cyc=1 from reset, so the first fetch is of RESET_PC.
REQ-023 SHALL, when reset is asserted mid-SHIFT, discard the partial PC, with no glitch on o_done.
REQ-024 SHALL take its first FSM transition on the first clk edge after i_rst_n rises.

Verification
REQ-025 SHALL cover reset: RESET_PC=0x100, release reset, ack after 3 cycles -> o_ibus_cyc high for 3 cycles, o_done pulses once, PC=0x100.
REQ-026 SHALL cover sequential increment: W=1 and W=4, PC=0x100, i_iscomp=0, no jump -> PC=0x104 after 32 and after 8 SHIFT cycles respectively; o_rd serialises 0x104 when i_jal_or_jalr=1.
REQ-027 SHALL cover a relative jump: PC=0x1000, i_pc_rel=1, i_jump=1, i_buf serialising 0xFFFFFFF1 -> PC=0x00000FF0, o_misalign=0.
REQ-028 SHALL cover misalignment: WITH_C=0, target 0x1002 -> o_misalign=1, PC=0x1002; WITH_C=1, same target -> o_misalign=0.
REQ-029 SHALL cover trap with wrap-around: i_trap=1, i_csr_pc=0x80000007 -> PC=0x80000004. Separately, PC=0xFFFFFFFC, increment 4 -> PC=0x00000000.
REQ-030 SHALL cover protocol edges: i_start during SHIFT/FETCH -> no effect; i_ibus_ack in IDLE -> no o_done; i_rst_n low at cnt=5 -> PC=RESET_PC, state FETCH.

Source files
------------

// File: rtl/serv_pc_seq.sv
// Bit-serial program counter sequencer: serialises the next-PC computation W bits
// per cycle, then holds the new PC on the instruction bus until the fetch is acknowledged.
module serv_pc_seq #(
  parameter int          W        = 1,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter bit          WITH_CSR = 1'b1,
  parameter bit          WITH_C   = 1'b0
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_jump,
  input  logic         i_jal_or_jalr,
  input  logic         i_utype,
  input  logic         i_pc_rel,
  input  logic         i_trap,
  input  logic         i_iscomp,
  input  logic [W-1:0] i_imm,
  input  logic [W-1:0] i_buf,
  input  logic [W-1:0] i_csr_pc,
  output logic [W-1:0] o_rd,
  output logic [W-1:0] o_bad_pc,
  output logic         o_misalign,
  output logic         o_busy,
  output logic         o_done,
  output logic [31:0]  o_ibus_adr,
  output logic         o_ibus_cyc,
  input  logic         i_ibus_ack
);

  localparam int N     = 32 / W;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, FETCH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cy4;
  logic             cyo;

  logic [31:0]  base;
  logic         cnt0;
  logic         cnt03;
  logic         cnt12to31;
  logic         iscomp_eff;
  logic         trap_eff;
  logic [W-1:0] pc_chunk;
  logic [W-1:0] inc_chunk;
  logic [W:0]   incr_sum;
  logic [W-1:0] offs_a;
  logic [W-1:0] offs_b;
  logic [W:0]   offs_sum;
  logic [W-1:0] incr;
  logic [W-1:0] offs;
  logic [W-1:0] aligned;
  logic [W-1:0] csr_chunk;
  logic [W-1:0] new_pc;
  logic         tgt_bit1;

  assign base       = 32'(cnt) * 32'(W);
  assign cnt0       = (cnt == '0);
  assign cnt03      = (base < 32'd4);
  assign cnt12to31  = (base >= 32'd12);
  assign iscomp_eff = WITH_C & i_iscomp;
  assign trap_eff   = WITH_CSR & i_trap;

  assign pc_chunk  = o_ibus_adr[W-1:0];
  assign inc_chunk = cnt03 ? W'((iscomp_eff ? 32'd2 : 32'd4) >> base) : '0;
  assign incr_sum  = {1'b0, pc_chunk} + {1'b0, inc_chunk} + {{W{1'b0}}, cy4};
  assign incr      = incr_sum[W-1:0];

  assign offs_a   = i_pc_rel ? pc_chunk : '0;
  assign offs_b   = i_utype ? (cnt12to31 ? i_imm : '0) : i_buf;
  assign offs_sum = {1'b0, offs_a} + {1'b0, offs_b} + {{W{1'b0}}, cyo};
  assign offs     = offs_sum[W-1:0];

  // Bit positions are tracked absolutely so the masks stay correct when W=1 spreads
  // bits [1:0] across two chunks.
  always_comb begin
    aligned   = offs;
    csr_chunk = i_csr_pc;
    tgt_bit1  = 1'b0;
    if (cnt0) aligned[0] = 1'b0;
    for (int j = 0; j < W; j++) begin
      if (base + 32'(j) < 32'd2) csr_chunk[j] = 1'b0;
      if (base + 32'(j) == 32'd1) tgt_bit1 = offs[j];
    end
  end

  assign new_pc   = trap_eff ? csr_chunk : (i_jump ? aligned : incr);
  assign o_bad_pc = aligned;
  assign o_rd     = (state == SHIFT) ?
                    ((i_utype ? aligned : '0) | (i_jal_or_jalr ? incr : '0)) : '0;
  assign o_busy     = (state != IDLE);
  assign o_ibus_cyc = (state == FETCH);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= FETCH;
      o_ibus_adr <= RESET_PC;
      cnt        <= '0;
      cy4        <= 1'b0;
      cyo        <= 1'b0;
      o_misalign <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= SHIFT;
            cnt        <= '0;
            cy4        <= 1'b0;
            cyo        <= 1'b0;
            o_misalign <= 1'b0;
          end
        end
        SHIFT: begin
          cnt        <= cnt + CNT_W'(1);
          cy4        <= incr_sum[W];
          cyo        <= offs_sum[W];
          o_ibus_adr <= {new_pc, o_ibus_adr[31:W]};
          if (!WITH_C && i_jump && !trap_eff && tgt_bit1) o_misalign <= 1'b1;
          if (cnt == CNT_W'(N - 1)) state <= FETCH;
        end
        FETCH: begin
          if (i_ibus_ack) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_pc_seq.sv
// Directed bench for serv_pc_seq: a W=1 (WITH_C=0) and a W=4 (WITH_C=1) instance
// driven one at a time, with hand-computed PC and rd values.
module tb_serv_pc_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start4, ack1, ack4;
  logic jump, jal, utype, pc_rel, trap, iscomp;
  logic [0:0]  imm1, buf1, csr1, rd1, bad1;
  logic [3:0]  imm4, buf4, csr4, rd4, bad4;
  logic        mis1, mis4, busy1, busy4, done1, done4, cyc1, cyc4;
  logic [31:0] adr1, adr4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serv_pc_seq #(.W(1), .RESET_PC(32'h100), .WITH_CSR(1'b1), .WITH_C(1'b0)) u_w1 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pc_rel), .i_trap(trap),
    .i_iscomp(iscomp), .i_imm(imm1), .i_buf(buf1), .i_csr_pc(csr1),
    .o_rd(rd1), .o_bad_pc(bad1), .o_misalign(mis1), .o_busy(busy1),
    .o_done(done1), .o_ibus_adr(adr1), .o_ibus_cyc(cyc1), .i_ibus_ack(ack1)
  );

  serv_pc_seq #(.W(4), .RESET_PC(32'h100), .WITH_CSR(1'b1), .WITH_C(1'b1)) u_w4 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_jump(jump),
    .i_jal_or_jalr(jal), .i_utype(utype), .i_pc_rel(pc_rel), .i_trap(trap),
    .i_iscomp(iscomp), .i_imm(imm4), .i_buf(buf4), .i_csr_pc(csr4),
    .o_rd(rd4), .o_bad_pc(bad4), .o_misalign(mis4), .o_busy(busy4),
    .o_done(done4), .o_ibus_adr(adr4), .o_ibus_cyc(cyc4), .i_ibus_ack(ack4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic j, input logic jl, input logic ut, input logic pr,
                         input logic tr);
    jump = j; jal = jl; utype = ut; pc_rel = pr; trap = tr;
  endtask

  // One full start/shift/fetch/ack transaction on the selected instance.
  task automatic do_seq(input bit sel, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] csr, input bit hold_start,
                        output logic [31:0] rd_col, output int nshift);
    int n;
    n = sel ? 8 : 32;
    rd_col = '0;
    nshift = 0;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    tick();
    if (!hold_start) begin start1 = 1'b0; start4 = 1'b0; end
    for (int k = 0; k < n; k++) begin
      if (sel) begin
        buf4 = 4'(b >> (4 * k)); imm4 = 4'(imm >> (4 * k)); csr4 = 4'(csr >> (4 * k));
      end else begin
        buf1 = b[k]; imm1 = imm[k]; csr1 = csr[k];
      end
      @(negedge clk);
      if (sel) begin
        rd_col |= 32'(rd4) << (4 * k);
        if (busy4 && !cyc4) nshift++;
      end else begin
        rd_col |= 32'(rd1) << k;
        if (busy1 && !cyc1) nshift++;
      end
      tick();
    end
    check("fetch_cyc", sel ? 32'(cyc4) : 32'(cyc1), 32'd1);
    tick();
    check("fetch_hold", sel ? 32'(cyc4) : 32'(cyc1), 32'd1);
    start1 = 1'b0; start4 = 1'b0;
    if (sel) ack4 = 1'b1; else ack1 = 1'b1;
    tick();
    ack1 = 1'b0; ack4 = 1'b0;
    check("done_pulse", sel ? 32'(done4) : 32'(done1), 32'd1);
    check("idle_after_ack", sel ? 32'(busy4) : 32'(busy1), 32'd0);
    tick();
    check("done_clear", sel ? 32'(done4) : 32'(done1), 32'd0);
  endtask

  task automatic jump_to(input bit sel, input logic [31:0] target);
    logic [31:0] rd;
    int ns;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_seq(sel, target, 32'd0, 32'd0, 1'b0, rd, ns);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int ns;
    int ncyc;
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; ack1 = 1'b0; ack4 = 1'b0;
    iscomp = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    imm1 = '0; buf1 = '0; csr1 = '0; imm4 = '0; buf4 = '0; csr4 = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_adr_w1", adr1, 32'h100);
    check("rst_adr_w4", adr4, 32'h100);
    check("rst_cyc", 32'(cyc1), 32'd1);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_misalign", 32'(mis1), 32'd0);

    // Release reset; ack arrives in the third FETCH cycle.
    rst_n = 1'b1;
    ncyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin ack1 = 1'b1; ack4 = 1'b1; end
      @(negedge clk);
      ncyc += int'(cyc1);
      tick();
    end
    ack1 = 1'b0; ack4 = 1'b0;
    check("rst_cyc_cycles", 32'(ncyc), 32'd3);
    check("rst_done_w1", 32'(done1), 32'd1);
    check("rst_done_w4", 32'(done4), 32'd1);
    check("rst_cyc_low", 32'(cyc1), 32'd0);
    tick();
    check("rst_done_once", 32'(done1), 32'd0);
    check("rst_pc_hold", adr1, 32'h100);

    // Sequential increment with rd = PC+4.
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_seq(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, rd, ns);
    check("inc_w1_pc", adr1, 32'h104);
    check("inc_w1_rd", rd, 32'h104);
    check("inc_w1_shifts", 32'(ns), 32'd32);
    do_seq(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, rd, ns);
    check("inc_w4_pc", adr4, 32'h104);
    check("inc_w4_rd", rd, 32'h104);
    check("inc_w4_shifts", 32'(ns), 32'd8);

    // Relative jump with negative offset.
    jump_to(1'b0, 32'h1000);
    check("abs_jump_pc", adr1, 32'h1000);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_seq(1'b0, 32'hFFFF_FFF1, 32'd0, 32'd0, 1'b0, rd, ns);
    check("rel_jump_pc", adr1, 32'h0000_0FF0);
    check("rel_jump_mis", 32'(mis1), 32'd0);

    // Misaligned target: flagged only without compressed support.
    jump_to(1'b0, 32'h1002);
    check("mis_w1_pc", adr1, 32'h1002);
    check("mis_w1_flag", 32'(mis1), 32'd1);
    jump_to(1'b1, 32'h1002);
    check("mis_w4_pc", adr4, 32'h1002);
    check("mis_w4_flag", 32'(mis4), 32'd0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_seq(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, rd, ns);
    check("mis_cleared", 32'(mis1), 32'd0);
    check("mis_inc_pc", adr1, 32'h1006);

    // Trap beats a simultaneous jump; low two bits of the vector are dropped.
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_seq(1'b0, 32'h0000_0055, 32'd0, 32'h8000_0007, 1'b0, rd, ns);
    check("trap_pc", adr1, 32'h8000_0004);
    check("trap_mis", 32'(mis1), 32'd0);

    // Wrap-around and AUIPC on the W=4 instance.
    jump_to(1'b1, 32'hFFFF_FFFC);
    check("wrap_pre", adr4, 32'hFFFF_FFFC);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_seq(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, rd, ns);
    check("wrap_pc", adr4, 32'h0000_0000);
    check("wrap_rd", rd, 32'h0000_0000);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_seq(1'b1, 32'd0, 32'h1234_5678, 32'd0, 1'b0, rd, ns);
    check("auipc_rd", rd, 32'h1234_5000);
    check("auipc_pc", adr4, 32'h0000_0004);

    // i_start held through SHIFT and FETCH changes nothing.
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_seq(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, rd, ns);
    check("start_hold_shifts", 32'(ns), 32'd32);
    check("start_hold_pc", adr1, 32'h8000_0008);

    // Ack while idle: no done, no activity.
    ack1 = 1'b1;
    tick();
    check("idle_ack_done", 32'(done1), 32'd0);
    tick();
    ack1 = 1'b0;
    check("idle_ack_busy", 32'(busy1), 32'd0);
    check("idle_ack_pc", adr1, 32'h8000_0008);

    // Reset asserted at cnt=5 mid-SHIFT.
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    buf1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", adr1, 32'h100);
    check("midrst_cyc", 32'(cyc1), 32'd1);
    check("midrst_done", 32'(done1), 32'd0);
    tick();
    rst_n = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ack1 = 1'b1; ack4 = 1'b1;
    tick();
    ack1 = 1'b0; ack4 = 1'b0;
    check("midrst_ack_done", 32'(done1), 32'd1);
    tick();
    do_seq(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, rd, ns);
    check("midrst_next_pc", adr1, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
